// File: rtl/mem_if_pkg.sv
// Shared constants, state encoding and request payload for the start/ready memory port.
package mem_if_pkg;

  localparam int unsigned AW          = 9;
  localparam int unsigned DW          = 16;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic          rwn;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_master_if.sv
// Memory-side start/ready handshake between mem_master (initiator) and mem (responder).
interface mem_master_if;
  import mem_if_pkg::*;

  logic          m_start;
  logic          m_rwn;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready;

  modport master (
    output m_start, m_rwn, m_address, m_wdata,
    input  m_rdata, m_ready
  );

  modport slave (
    input  m_start, m_rwn, m_address, m_wdata,
    output m_rdata, m_ready
  );

endinterface

// File: rtl/mem_master.sv
// Serialises data-port and two-word instruction-fetch requests onto the single memory port,
// with fixed data-over-fetch priority and a WAIT timeout that completes the request with err.
module mem_master
  import mem_if_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_done,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [2*DW-1:0] if_rdata,
  output logic            if_done,
  output logic            err,
  mem_master_if.master    m
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  state_t          w_state_next;
  logic            w_latch;
  logic            w_next_word;
  logic            w_finish;
  logic            w_timeout;

  mem_req_t        r_req;
  logic            r_fetch;
  logic            r_second;
  logic [CW-1:0]   r_cnt;
  logic            r_start;
  logic [DW-1:0]   r_word0;
  logic [DW-1:0]   r_d_rdata;
  logic [2*DW-1:0] r_if_rdata;
  logic            r_d_done;
  logic            r_if_done;
  logic            r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next state plus one-cycle strobes that steer the datapath registers.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_next_word  = 1'b0;
    w_finish     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (m.m_ready && (d_req || if_req)) begin
          w_latch      = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: w_state_next = WAIT;
      WAIT: begin
        if (m.m_ready) begin
          if (r_fetch && !r_second) begin
            w_next_word  = 1'b1;
            w_state_next = ISSUE;
          end else begin
            w_finish     = 1'b1;
            w_state_next = RESP;
          end
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req      <= '{rwn: 1'b1, addr: '0, wdata: '0};
      r_fetch    <= 1'b0;
      r_second   <= 1'b0;
      r_cnt      <= '0;
      r_start    <= 1'b0;
      r_word0    <= '0;
      r_d_rdata  <= '0;
      r_if_rdata <= '0;
      r_d_done   <= 1'b0;
      r_if_done  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_start   <= (w_state_next == ISSUE);
      r_d_done  <= 1'b0;
      r_if_done <= 1'b0;
      r_err     <= 1'b0;

      // Data wins over fetch; the losing fetch is picked up in a later IDLE.
      if (w_latch) begin
        r_fetch  <= !d_req;
        r_second <= 1'b0;
        if (d_req) r_req <= '{rwn: !d_we, addr: d_addr, wdata: d_wdata};
        else       r_req <= '{rwn: 1'b1, addr: if_addr, wdata: '0};
      end

      if (r_state == ISSUE)     r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= r_cnt + CW'(1);

      // Opcode word is staged so if_rdata only changes when the whole fetch completes.
      if (w_next_word) begin
        r_word0    <= m.m_rdata;
        r_second   <= 1'b1;
        r_req.addr <= r_req.addr + AW'(1);
      end

      if (w_finish || w_timeout) begin
        r_err <= w_timeout;
        if (r_fetch) begin
          r_if_done  <= 1'b1;
          r_if_rdata <= w_timeout ? '0 : {r_word0, m.m_rdata};
        end else begin
          r_d_done <= 1'b1;
          if (r_req.rwn) r_d_rdata <= w_timeout ? '0 : m.m_rdata;
        end
      end
    end
  end

  assign m.m_start   = r_start;
  assign m.m_rwn     = r_req.rwn;
  assign m.m_address = r_req.addr;
  assign m.m_wdata   = r_req.wdata;

  assign d_rdata  = r_d_rdata;
  assign d_done   = r_d_done;
  assign if_rdata = r_if_rdata;
  assign if_done  = r_if_done;
  assign err      = r_err;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with an inline start/ready memory responder and a done scoreboard.
module tb_mem_master;
  import mem_if_pkg::*;

  localparam int unsigned TO = 15;

  typedef struct {
    logic        fetch;
    logic        err;
    logic [31:0] data;
    int          cyc;
    int          starts;
  } exp_t;

  logic            clk;
  logic            reset_n;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW-1:0]   d_rdata;
  logic            d_done;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [2*DW-1:0] if_rdata;
  logic            if_done;
  logic            err;

  logic            mm_ready = 1'b1;
  logic [DW-1:0]   mm_rdata = '0;
  int              mm_rem   = 0;
  logic            hold_ready = 1'b0;
  logic [DW-1:0]   mem_arr [0:(1<<AW)-1];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_starts = 0;
  exp_t sb[$];

  mem_master_if mif ();

  assign mif.m_ready = mm_ready;
  assign mif.m_rdata = mm_rdata;

  mem_master #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .err      (err),
    .m        (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Responder: ready drops at the start edge and returns at edge E+1+address[1:0].
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      mm_ready <= 1'b1;
      mm_rem   <= 0;
    end else if (mif.m_start) begin
      mm_ready <= 1'b0;
      mm_rem   <= int'(mif.m_address[1:0]);
      if (!mif.m_rwn) mem_arr[mif.m_address] <= mif.m_wdata;
      else            mm_rdata <= mem_arr[mif.m_address];
    end else if (!mm_ready && !hold_ready) begin
      if (mm_rem == 0) mm_ready <= 1'b1;
      else             mm_rem   <= mm_rem - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_done(input logic f, input logic e, input logic [31:0] data,
                             input int c, input int s);
    exp_t x;
    x.fetch  = f;
    x.err    = e;
    x.data   = data;
    x.cyc    = c;
    x.starts = s;
    sb.push_back(x);
  endtask

  task automatic drive_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
  endtask

  task automatic drive_fetch(input logic [AW-1:0] a);
    if_addr = a;
    if_req  = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((d_req || if_req) && n < budget) begin
      @(negedge clk);
      n++;
      if (d_done)  d_req  = 1'b0;
      if (if_done) if_req = 1'b0;
    end
    check("req_outstanding", {30'd0, d_req, if_req}, 32'd0);
    d_req  = 1'b0;
    if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks start discipline.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        n_starts = 0;
      end else begin
        if (mif.m_start) begin
          n_starts++;
          check("start_while_busy", {31'd0, mif.m_ready}, 32'd1);
        end
        if (d_done || if_done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", {30'd0, d_done, if_done}, 32'd0);
          end else begin
            x = sb.pop_front();
            check("done_kind", {30'd0, d_done, if_done}, x.fetch ? 32'd1 : 32'd2);
            check("done_cycle", 32'(cyc), 32'(x.cyc));
            check("err", {31'd0, err}, {31'd0, x.err});
            check("start_count", 32'(n_starts), 32'(x.starts));
            if (x.fetch) check("if_rdata", if_rdata, x.data);
            else         check("d_rdata", {16'd0, d_rdata}, x.data);
          end
          n_starts = 0;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    if_req  = 1'b0;
    if_addr = '0;
    for (int i = 0; i < (1 << AW); i++) mem_arr[i] <= 16'(i);
    mem_arr[17]  <= 16'h0010;
    mem_arr[1]   <= 16'h8C00;
    mem_arr[2]   <= 16'h00A0;
    mem_arr[511] <= 16'h1234;
    mem_arr[0]   <= 16'h5678;
    mem_arr[18]  <= 16'h2222;
    mem_arr[5]   <= 16'h5555;
    mem_arr[16]  <= 16'hABCD;
    mem_arr[3]   <= 16'h3333;

    repeat (3) @(negedge clk);
    check("rst_m_start", {31'd0, mif.m_start}, 32'd0);
    check("rst_m_rwn", {31'd0, mif.m_rwn}, 32'd1);
    check("rst_m_address", 32'(mif.m_address), 32'd0);
    check("rst_d_done", {30'd0, d_done, if_done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Load addr 17 (k=1): done at C0+5.
    drive_data(1'b0, 9'd17, 16'h0000);
    expect_done(1'b0, 1'b0, 32'h0010, cyc + 5, 1);
    wait_done(40);

    // Store 27 (k=3) keeps d_rdata; then load it back.
    drive_data(1'b1, 9'd27, 16'hBEEF);
    expect_done(1'b0, 1'b0, 32'h0010, cyc + 7, 1);
    wait_done(40);
    drive_data(1'b0, 9'd27, 16'h0000);
    expect_done(1'b0, 1'b0, 32'hBEEF, cyc + 7, 1);
    wait_done(40);

    // Fetch at 1: k0=1, k1=2 -> C0+10.
    drive_fetch(9'd1);
    expect_done(1'b1, 1'b0, 32'h8C0000A0, cyc + 10, 2);
    wait_done(40);

    // Fetch at 511 wraps to 0: k0=3, k1=0 -> C0+10.
    drive_fetch(9'd511);
    expect_done(1'b1, 1'b0, 32'h12345678, cyc + 10, 2);
    wait_done(40);

    // Simultaneous: data addr 18 (k=2) at C0+6, fetch from IDLE at C0+7 finishes C0+17.
    drive_data(1'b0, 9'd18, 16'h0000);
    drive_fetch(9'd1);
    expect_done(1'b0, 1'b0, 32'h2222, cyc + 6, 1);
    expect_done(1'b1, 1'b0, 32'h8C0000A0, cyc + 17, 2);
    wait_done(40);

    // Ready held low: TO WAIT cycles then RESP with err and zeroed data.
    hold_ready = 1'b1;
    drive_data(1'b0, 9'd5, 16'h0000);
    expect_done(1'b0, 1'b1, 32'h0000, cyc + 2 + TO, 1);
    wait_done(40);
    hold_ready = 1'b0;
    repeat (4) @(negedge clk);
    drive_data(1'b0, 9'd16, 16'h0000);
    expect_done(1'b0, 1'b0, 32'hABCD, cyc + 4, 1);
    wait_done(40);

    // Reset in the middle of WAIT abandons the load silently.
    drive_data(1'b0, 9'd3, 16'h0000);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_m_start", {31'd0, mif.m_start}, 32'd0);
    check("mid_rst_m_rwn", {31'd0, mif.m_rwn}, 32'd1);
    check("mid_rst_m_address", 32'(mif.m_address), 32'd0);
    check("mid_rst_d_rdata", {16'd0, d_rdata}, 32'd0);
    check("mid_rst_if_rdata", if_rdata, 32'd0);
    check("mid_rst_done", {29'd0, d_done, if_done, err}, 32'd0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    drive_data(1'b0, 9'd17, 16'h0000);
    expect_done(1'b0, 1'b0, 32'h0010, cyc + 5, 1);
    wait_done(40);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
